// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised register file: one decoded write port, two registered read ports
// Optional same-edge write forwarding is enabled by defining REGFILE_WRITE_BYPASS_EN.
module reg_file_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             read,
  input  logic             write,
  input  logic [AW-1:0]    addr_r1,
  input  logic [AW-1:0]    addr_r2,
  input  logic [AW-1:0]    addr_w,
  input  logic [WIDTH-1:0] data_w,
  output logic [WIDTH-1:0] data_r1,
  output logic [WIDTH-1:0] data_r2
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] we;
  logic [WIDTH-1:0] rd1, rd2;

  // An address is live when it maps to real storage and is not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    we = '0;
    for (int i = 0; i < DEPTH; i++) begin
      we[i] = write && (int'(addr_w) == i) && addr_ok(addr_w);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we[i]) mem[i] <= data_w;
      end
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (addr_ok(addr_r1)) rd1 = mem[addr_r1];
    if (addr_ok(addr_r2)) rd2 = mem[addr_r2];
`ifdef REGFILE_WRITE_BYPASS_EN
    // A dead write address never forwards, so such a port keeps returning zero.
    if (write && addr_ok(addr_w) && (addr_r1 == addr_w)) rd1 = data_w;
    if (write && addr_ok(addr_w) && (addr_r2 == addr_w)) rd2 = data_w;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r1 <= '0;
      data_r2 <= '0;
    end else if (read) begin
      data_r1 <= rd1;
      data_r2 <= rd2;
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - bench for reg_file_param across four parameter sets
module tb_reg_file_param;
  localparam int NI = 4;
  localparam int PW [NI] = '{32, 32, 8, 1};
  localparam int PD [NI] = '{32, 32, 12, 2};
  localparam int PZ [NI] = '{0, 1, 1, 0};
  localparam int PA [NI] = '{5, 5, 4, 1};

  logic clk = 1'b0;
  logic reset, read, write;
  logic [7:0] ar1, ar2, aw;
  logic [31:0] dw;
  logic [31:0] r1_0, r2_0, r1_1, r2_1;
  logic [7:0] r1_2, r2_2;
  logic r1_3, r2_3;

  always #5 clk = ~clk;

  reg_file_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0)) u0 (
    .clk(clk), .reset(reset), .read(read), .write(write),
    .addr_r1(ar1[4:0]), .addr_r2(ar2[4:0]), .addr_w(aw[4:0]),
    .data_w(dw), .data_r1(r1_0), .data_r2(r2_0));
  reg_file_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) u1 (
    .clk(clk), .reset(reset), .read(read), .write(write),
    .addr_r1(ar1[4:0]), .addr_r2(ar2[4:0]), .addr_w(aw[4:0]),
    .data_w(dw), .data_r1(r1_1), .data_r2(r2_1));
  reg_file_param #(.WIDTH(8), .DEPTH(12), .ZERO_REG(1)) u2 (
    .clk(clk), .reset(reset), .read(read), .write(write),
    .addr_r1(ar1[3:0]), .addr_r2(ar2[3:0]), .addr_w(aw[3:0]),
    .data_w(dw[7:0]), .data_r1(r1_2), .data_r2(r2_2));
  reg_file_param #(.WIDTH(1), .DEPTH(2), .ZERO_REG(0)) u3 (
    .clk(clk), .reset(reset), .read(read), .write(write),
    .addr_r1(ar1[0]), .addr_r2(ar2[0]), .addr_w(aw[0]),
    .data_w(dw[0]), .data_r1(r1_3), .data_r2(r2_3));

  logic [31:0] m  [NI][32];
  logic [31:0] e1 [NI];
  logic [31:0] e2 [NI];
  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] msk(int k);
    return (PW[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << PW[k]) - 32'd1);
  endfunction

  function automatic int loc(int k, logic [7:0] a);
    return int'(a) % (1 << PA[k]);
  endfunction

  function automatic bit live(int k, int a);
    return (a < PD[k]) && !(PZ[k] == 1 && a == 0);
  endfunction

  function automatic logic [31:0] peek(int k, int a);
    return live(k, a) ? m[k][a] : 32'h0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int j = 0; j < 32; j++) m[k][j] = '0;
      e1[k] = '0;
      e2[k] = '0;
    end
  endtask

  task automatic model_edge();
    int a1, a2, w;
    logic [31:0] v1, v2;
    if (reset) begin
      model_reset();
    end else begin
      for (int k = 0; k < NI; k++) begin
        a1 = loc(k, ar1);
        a2 = loc(k, ar2);
        w  = loc(k, aw);
        v1 = peek(k, a1);
        v2 = peek(k, a2);
`ifdef REGFILE_WRITE_BYPASS_EN
        if (write && live(k, w)) begin
          if (a1 == w) v1 = dw & msk(k);
          if (a2 == w) v2 = dw & msk(k);
        end
`endif
        if (read) begin
          e1[k] = v1;
          e2[k] = v2;
        end
        if (write && live(k, w)) m[k][w] = dw & msk(k);
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] got(int k, int p);
    case (k)
      0: return (p == 1) ? r1_0 : r2_0;
      1: return (p == 1) ? r1_1 : r2_1;
      2: return {24'h0, (p == 1) ? r1_2 : r2_2};
      3: return {31'h0, (p == 1) ? r1_3 : r2_3};
      default: return 'x;
    endcase
  endfunction

  task automatic chk1(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check(string tag);
    logic [31:0] obs, exp;
    for (int k = 0; k < NI; k++) begin
      for (int p = 1; p <= 2; p++) begin
        obs = got(k, p);
        exp = (p == 1) ? e1[k] : e2[k];
        tests++;
        assert (obs === exp) else begin
          fails++;
          $error("FAIL %s inst%0d port%0d observed=%h expected=%h", tag, k, p, obs, exp);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0;
    ar1 = '0; ar2 = '0; aw = '0; dw = '0;
    model_reset();
    #1;
    check("reset_start");
    write = 1'b1; read = 1'b1; dw = 32'h1234_5678;
    tick();
    check("reset_hold");
    reset = 1'b0; write = 1'b0; read = 1'b0;

    write = 1'b1; aw = 8'd5; dw = 32'hDEAD_BEEF;
    tick();
    write = 1'b0; read = 1'b1; ar1 = 8'd5; ar2 = 8'd5;
    tick();
    read = 1'b0;
    check("rd5");
    chk1("rd5_const", r1_0, 32'hDEAD_BEEF);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check("reset_async");
    chk1("reset_async_const", r1_0, 32'h0);
    #2;
    reset = 1'b0;
    read = 1'b1; ar1 = 8'd5;
    tick();
    check("rd5_after_reset");

    read = 1'b0; write = 1'b1;
    for (int i = 0; i < 32; i++) begin
      aw = 8'(i);
      dw = 32'(i) * 32'h0101_0101;
      tick();
    end
    write = 1'b0; read = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ar1 = 8'(i);
      ar2 = 8'(31 - i);
      tick();
      check("fill_pair");
    end
    chk1("fill_const", r1_0, 32'h1F1F_1F1F);
    read = 1'b0; ar1 = 8'd3; ar2 = 8'd9;
    repeat (3) begin
      tick();
      check("read_hold");
    end

    write = 1'b1; aw = 8'd0; dw = 32'hFFFF_FFFF;
    tick();
    write = 1'b0; read = 1'b1; ar1 = 8'd0; ar2 = 8'd0;
    tick();
    check("zero_reg");
    chk1("zero_const", r1_1, 32'h0);

    write = 1'b1; read = 1'b0; aw = 8'd7; dw = 32'h11;
    tick();
    read = 1'b1; ar1 = 8'd7; ar2 = 8'd7; dw = 32'h22;
    tick();
    write = 1'b0;
    check("same_edge");
`ifdef REGFILE_WRITE_BYPASS_EN
    chk1("same_edge_const", r1_0, 32'h22);
`else
    chk1("same_edge_const", r1_0, 32'h11);
`endif
    tick();
    check("same_edge_next");
    chk1("same_edge_next_const", r1_0, 32'h22);

    write = 1'b1; read = 1'b0; aw = 8'd13; dw = 32'hAA;
    tick();
    write = 1'b0; read = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ar1 = 8'(i);
      ar2 = 8'(15 - i);
      tick();
      check("npot");
    end
    ar1 = 8'd13;
    tick();
    chk1("npot13_const", {24'h0, r1_2}, 32'h0);

    write = 1'b1; aw = 8'd3; dw = 32'hCAFE_F00D; read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    tick();
    reset = 1'b0; write = 1'b0; read = 1'b1; ar1 = 8'd3; ar2 = 8'd3;
    tick();
    check("reset_mid_write");

    for (int i = 0; i < 8; i++) begin
      write = 1'b1; read = 1'b1;
      ar1 = aw; ar2 = 8'(i % 2);
      aw = 8'(i % 2);
      dw = 32'(i % 3 == 0);
      tick();
      check("narrow");
    end
    write = 1'b0;

    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      read  = 1'($urandom);
      write = 1'($urandom);
      ar1 = 8'($urandom_range(0, 31));
      ar2 = ($urandom_range(0, 3) == 0) ? ar1 : 8'($urandom_range(0, 31));
      aw  = ($urandom_range(0, 3) == 0) ? ar1 : 8'($urandom_range(0, 31));
      dw  = $urandom;
      tick();
      check("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised multi-register file: successor to the fixed 32-bit register and 5x32 decoder primitives. It stores DEPTH words of WIDTH bits and provides one decoded write port and two registered read ports. An optional hardwired-zero register 0 is available. It sits between the datapath ALU and the instruction decode stage and replaces hand-instantiated register banks.

## Interface
- WIDTH, 32: bits per register, 1..64.
- DEPTH, 32: number of registers, 2..256.
- ZERO_REG, 1: 1 makes register 0 read as 0 and ignore writes; 0 makes it a normal register.
- Derived, not overridable: AW = clog2(DEPTH), the address width.
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- READ  in  1  read strobe; captures both read ports on the rising edge.
- WRITE  in  1  write strobe; commits DATA_W on the rising edge.
- ADDR_R1  in  AW  read port 1 address.
- ADDR_R2  in  AW  read port 2 address.
- ADDR_W  in  AW  write address.
- DATA_W  in  WIDTH  write data.
- DATA_R1  out  WIDTH  registered read data, port 1.
- DATA_R2  out  WIDTH  registered read data, port 2.

## Operation
- Storage: DEPTH x WIDTH flops. Write-enable decode is one-hot from ADDR_W.
- Write: when WRITE=1 at a rising CLK, reg[ADDR_W] <= DATA_W. When WRITE=0, all registers hold.
- Read: when READ=1 at a rising CLK:
  - DATA_R1 <= reg[ADDR_R1].
  - DATA_R2 <= reg[ADDR_R2].
- When READ=0, DATA_R1 and DATA_R2 hold their last value indefinitely.
- Read value is the content before the same-edge write, unless the bypass macro is enabled (see Configuration).
- Both read ports may address the same register. Each independently returns the same value.
- ZERO_REG=1:
  - A write to address 0 is discarded.
  - A read of address 0 returns all-zeros.
- Out-of-range addresses apply only when DEPTH is not a power of two:
  - A write to address >= DEPTH is discarded. No other register is disturbed.
  - A read of address >= DEPTH returns all-zeros.
- No internal state machine beyond storage. Output registers are updated only by READ or RESET.

## Timing
- RESET=1 asserts asynchronously, without waiting for CLK:
  - every register goes to 0;
  - DATA_R1 = 0 and DATA_R2 = 0;
  - READ and WRITE are ignored while RESET is high.
- RESET deassertion: the first rising CLK with RESET=0 performs a normal read/write.
- RESET asserted mid-write: the write is lost and the register is 0.
- Write latency: data written at edge N is readable by a READ at edge N+1 (or at edge N with bypass enabled).
- Read latency: 1 cycle. DATA_Rx is valid after the edge at which READ=1.
- Read addresses and DATA_W must be stable at the rising edge. There is no combinational path from any input to any output.

## Configuration
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: write-through forwarding. On an edge with READ=1, WRITE=1 and ADDR_Rx == ADDR_W, DATA_Rx <= DATA_W.
  - Forwarding is suppressed when ZERO_REG=1 and the address is 0; the port returns 0.
  - Forwarding is suppressed when ADDR_W >= DEPTH; the port returns 0.
- Undefined: no forwarding. The port returns the old register content, i.e. read-before-write.
- Storage behaviour is identical in both builds.

## Test plan
- Reset: load reg[5] = 0xDEADBEEF, READ it, then pulse RESET between edges -> DATA_R1 = 0 immediately (asynchronous). A subsequent READ of address 5 -> 0.
- Fill/readback: write reg[i] = i*0x01010101 for all i with WIDTH=32, DEPTH=32, ZERO_REG=0. Then read pairs (i, 31-i) -> both ports match. Drop READ for 3 cycles -> outputs unchanged.
- Zero register: with ZERO_REG=1, write 0xFFFFFFFF to address 0, then read address 0 on both ports -> 0x00000000.
- Same-edge conflict: reg[7] = 0x11, then READ=WRITE=1, ADDR_R1=ADDR_W=7, DATA_W=0x22:
  - without REGFILE_WRITE_BYPASS_EN -> DATA_R1 = 0x11, next READ = 0x22;
  - with the macro -> DATA_R1 = 0x22.
- Non-power-of-two: with DEPTH=12, WIDTH=8, write 0xAA to address 13 -> reads of all 12 registers unchanged. A read of address 13 -> 0x00.
- Narrow config: with WIDTH=1, DEPTH=2, ZERO_REG=0, alternate writes of 1/0 to addresses 0/1 -> reads track the writes with 1-cycle latency.
